ram_burst_ctrl: RTL and testbench

Burst access controller that acts as the initiator for the single-port async-read RAM (8-bit words, 16 locations). It accepts one command at a time: a start address, a length, and a direction. It then drives the RAM address, write-data and write-enable pins to fill a burst from a valid/ready input stream, or to drain a burst into a registered valid/ready output stream. It sits between stream-side logic and the RAM, so no other block ever toggles the RAM pins directly.

---
 rtl/ram_burst_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a 16x8 single-port async-read RAM: fills a burst from a write
// stream or drains one into a registered read stream. Optional checksum: RAM_BURST_CHK_EN.
module ram_burst_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    input  logic          rd_ready,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
`ifdef RAM_BURST_CHK_EN
    ,
    output logic [DW-1:0] chk
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_s;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] cnt_r;
    logic          more_r;      // read words still to be fetched from the RAM
    logic          rd_valid_r;
    logic          rd_last_r;
    logic [DW-1:0] rd_data_r;
    logic          accept_s;
    logic          wr_beat_s;
    logic          rd_load_s;
    logic          rd_hs_s;

`ifdef RAM_BURST_CHK_EN
    logic [DW-1:0] chk_r;

    function automatic logic [DW-1:0] xor_acc(input logic [DW-1:0] acc, input logic [DW-1:0] word);
        return acc ^ word;
    endfunction
`endif

    // Handshake qualifiers and pin drive decoded from the current state
    always_comb begin
        accept_s  = cmd_valid && (state_r == IDLE);
        wr_beat_s = (state_r == WRITE) && wr_valid;
        rd_load_s = (state_r == READ) && more_r && (!rd_valid_r || rd_ready);
        rd_hs_s   = (state_r == READ) && rd_valid_r && rd_ready;
        cmd_ready = (state_r == IDLE);
        wr_ready  = (state_r == WRITE);
        ram_we    = wr_beat_s;
        done      = (state_r == DONE);
        ram_addr  = addr_r;
        if (state_r == WRITE) begin
            ram_wdata = wr_data;
        end else begin
            ram_wdata = {DW{1'b0}};
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = cmd_write ? WRITE : READ;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (wr_beat_s && (cnt_r == '0)) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                end
            end
            READ: begin
                if (rd_hs_s && rd_last_r) begin
                    state_s = DONE;
                end else begin
                    state_s = READ;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Burst address and remaining-word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= {AW{1'b0}};
            cnt_r  <= {AW{1'b0}};
            more_r <= 1'b0;
        end else if (accept_s) begin
            addr_r <= cmd_addr;
            cnt_r  <= cmd_len;
            more_r <= !cmd_write;
        end else if (wr_beat_s || rd_load_s) begin
            addr_r <= addr_r + ADDR_ONE;
            if (cnt_r != '0) begin
                cnt_r <= cnt_r - ADDR_ONE;
            end
            if (rd_load_s) begin
                more_r <= (cnt_r != '0);
            end
        end
    end

    // Read stream output register; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DW{1'b0}};
            rd_last_r  <= 1'b0;
        end else if (rd_load_s) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= ram_rdata;
            rd_last_r  <= (cnt_r == '0);
        end else if (rd_hs_s) begin
            rd_valid_r <= 1'b0;
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign rd_last  = rd_last_r;

`ifdef RAM_BURST_CHK_EN
    // XOR checksum over every word moved in the current burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_r <= {DW{1'b0}};
        end else if (accept_s) begin
            chk_r <= {DW{1'b0}};
        end else if (wr_beat_s) begin
            chk_r <= xor_acc(chk_r, wr_data);
        end else if (rd_load_s) begin
            chk_r <= xor_acc(chk_r, ram_rdata);
        end
    end

    assign chk = chk_r;
`endif

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed self-checking bench for ram_burst_ctrl with a behavioural 16x8 async-read RAM.
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_last, rd_ready;
    logic [7:0] rd_data;
    logic       done;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       ram_we;
`ifdef RAM_BURST_CHK_EN
    logic [7:0] chk;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [16];
    logic       mem_init;
    logic [7:0] wr_vec [16];
    logic [7:0] exp_rd [16];

    always #5 clk = ~clk;

    ram_burst_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
`ifdef RAM_BURST_CHK_EN
        , .chk(chk)
`endif
    );

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hE0 | 8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic issue_cmd(input logic wr, input int addr, input int len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = 4'(addr);
        cmd_len   = 4'(len);
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    endtask

    task automatic do_write(input int addr, input int len, input int gap);
        logic [7:0] x = 8'h00;
        issue_cmd(1'b1, addr, len);
        for (int i = 0; i <= len; i++) begin
            wr_valid = 1'b1;
            wr_data  = wr_vec[i];
            x        = x ^ wr_vec[i];
            @(negedge clk);
            check("wr_we", 32'(ram_we), 32'd1);
            check("wr_addr", 32'(ram_addr), 32'((addr + i) % 16));
            check("wr_wdata", 32'(ram_wdata), 32'(wr_vec[i]));
            @(posedge clk); #1;
            if (i < len) begin
                for (int g = 0; g < gap; g++) begin
                    wr_valid = 1'b0;
                    @(negedge clk);
                    check("gap_we", 32'(ram_we), 32'd0);
                    check("gap_ready", 32'(wr_ready), 32'd1);
                    @(posedge clk); #1;
                end
            end
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check("wr_done", 32'(done), 32'd1);
        check("wr_we_after", 32'(ram_we), 32'd0);
`ifdef RAM_BURST_CHK_EN
        check("wr_chk", 32'(chk), 32'(x));
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check("wr_done_clr", 32'(done), 32'd0);
        check("wr_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input int addr, input int len, input int mode);
        int         got = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] x = 8'h00;
        issue_cmd(1'b0, addr, len);
        while (got <= len && cyc < 200) begin
            rd_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            @(negedge clk);
            if (cyc == 0) check("rd_we", 32'(ram_we), 32'd0);
            if (stalled) begin
                check("rd_hold_valid", 32'(rd_valid), 32'd1);
                check("rd_hold_data", 32'(rd_data), 32'(held));
            end
            if (rd_valid) begin
                if (rd_ready) begin
                    check("rd_data", 32'(rd_data), 32'(exp_rd[got]));
                    check("rd_last", 32'(rd_last), 32'(got == len));
                    x = x ^ exp_rd[got];
                    got++;
                    stalled = 1'b0;
                end else begin
                    held    = rd_data;
                    stalled = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        rd_ready = 1'b0;
        check("rd_count", 32'(got), 32'(len + 1));
        @(negedge clk);
        check("rd_done", 32'(done), 32'd1);
        check("rd_valid_clr", 32'(rd_valid), 32'd0);
`ifdef RAM_BURST_CHK_EN
        check("rd_chk", 32'(chk), 32'(x));
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_done_clr", 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef RAM_BURST_CHK_EN
        check("rst_chk", 32'(chk), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mem_init = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd0;
        wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1; mem_init = 1'b0;

        // single word write then read at address 3
        wr_vec[0] = 8'hA5;
        do_write(3, 0, 0);
        exp_rd[0] = 8'hA5;
        do_read(3, 0, 0);

        // full-depth write from 12 wraps: mem[(12+i)%16] = i
        for (int i = 0; i < 16; i++) wr_vec[i] = 8'(i);
        do_write(12, 15, 0);
        for (int i = 0; i < 16; i++) exp_rd[i] = 8'((i + 4) % 16);
        do_read(0, 15, 0);

        // backpressured read of 5..8 -> 0x09..0x0C
        exp_rd[0] = 8'h09; exp_rd[1] = 8'h0A; exp_rd[2] = 8'h0B; exp_rd[3] = 8'h0C;
        do_read(5, 3, 1);

        // write with two idle cycles between beats
        wr_vec[0] = 8'h31; wr_vec[1] = 8'h32; wr_vec[2] = 8'h33;
        do_write(8, 2, 2);
        exp_rd[0] = 8'h31; exp_rd[1] = 8'h32; exp_rd[2] = 8'h33;
        do_read(8, 2, 1);

        // reset after 2 of 4 write beats at address 0
        issue_cmd(1'b1, 0, 3);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hC0 | 8'(i);
            @(posedge clk); #1;
        end
        wr_data = 8'hC2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        check("rst_mid_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_done2", 32'(done), 32'd0);
        check("rst_mid_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        exp_rd[0] = 8'hC0; exp_rd[1] = 8'hC1; exp_rd[2] = 8'h06; exp_rd[3] = 8'h07;
        do_read(0, 3, 0);

        // checksum burst: 0x11 ^ 0x22 ^ 0x44 = 0x77
        wr_vec[0] = 8'h11; wr_vec[1] = 8'h22; wr_vec[2] = 8'h44;
        do_write(10, 2, 0);
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h44;
        do_read(10, 2, 0);
`ifdef RAM_BURST_CHK_EN
        check("chk_hold", 32'(chk), 32'h77);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
